// File: rtl/line_serializer.sv
// Line serializer: holds one packed line and streams it out byte-wise,
// framed by a sync byte and an 8-bit line index, over a valid/ready port.
module line_serializer #(
  parameter int          HSIZE     = 768,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [HSIZE-1:0] line_in,
  input  logic             line_valid,
  output logic             line_ready,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             overrun,
  output logic [7:0]       drop_count
);

  localparam int NB = HSIZE / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_IDX  = 2'd2;
  localparam logic [1:0] S_PAY  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [HSIZE-1:0] line_q, line_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [7:0]       drop_q, drop_d;
  logic             hs;

  assign hs      = valid_q && m_ready;
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    drop_d  = drop_q;
    unique case (state_q)
      S_IDLE: begin
        if (line_valid) begin
          line_d  = line_in;
          cnt_d   = '0;
          state_d = S_SYNC;
          valid_d = 1'b1;
          data_d  = SYNC_BYTE;
        end
      end
      S_SYNC: begin
        if (hs) begin
          state_d = S_IDX;
          data_d  = idx_q;
        end
      end
      S_IDX: begin
        if (hs) begin
          state_d = S_PAY;
          cnt_d   = '0;
          data_d  = line_q[7:0];
        end
      end
      S_PAY: begin
        if (hs) begin
          if (cnt_q == LAST) begin
            valid_d = 1'b0;
            idx_d   = idx_q + 8'd1;
            state_d = S_IDLE;
          end else begin
            cnt_d  = cnt_inc;
            data_d = line_q[{cnt_inc, 3'b000} +: 8];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // a line offered while a frame is still draining is lost
    if (line_valid && state_q != S_IDLE) begin
      ovr_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      drop_q  <= drop_d;
    end
  end

  assign line_ready = (state_q == S_IDLE);
  assign busy       = !line_ready;
  assign m_data     = data_q;
  assign m_valid    = valid_q;
  assign overrun    = ovr_q;
  assign drop_count = drop_q;

endmodule
